// File: rtl/mem_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_hs
// Purpose  : MEM pipeline stage with a req/ack handshake to a variable-latency
//            data memory. It resolves branch/jump, forwards the MEM result to
//            EX and drives the MEM/WB register. A small FSM stalls the pipeline
//            until the access completes. Load data is parked in a hold register
//            while WB is frozen.
// Options  : MEM_TIMEOUT_EN - when defined, a BUSY watchdog moves the FSM to a
//            sticky ERR state after TIMEOUT_CYCLES cycles without ack.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_hs #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int IMM_WIDTH      = 8,
  parameter int REG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [IMM_WIDTH-1:0]  immM_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MovM_i,
  input  logic                  jumpM_i,
  input  logic                  MemSrc_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  stall_MEM_WB_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  input  logic                  dm_ack_i,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  output logic                  stall_o,
  output logic                  PC_src_o,
  output logic [ADDR_WIDTH-1:0] branchAddr_o,
  output logic [ADDR_WIDTH-1:0] jumpAddr_o,
  output logic                  jumpM_o,
  output logic [DATA_WIDTH-1:0] WBResultM_w,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic [REG_WIDTH-1:0]  WriteRegM_o,
  output logic                  RegWriteM_o,
  output logic                  err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
`ifdef MEM_TIMEOUT_EN
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam int         CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] wbres_q;
  logic [REG_WIDTH-1:0]  wreg_q;
  logic                  rw_q;

  logic                  w_memop;
  logic                  w_idle_req;
  logic [ADDR_WIDTH-1:0] w_imm_addr;
  logic [DATA_WIDTH-1:0] w_imm_sext;
  logic [DATA_WIDTH-1:0] w_commit_data;
  logic                  unused_dbg;

  // Immediate as an address: truncate or zero-extend to ADDR_WIDTH.
  generate
    if (IMM_WIDTH >= ADDR_WIDTH) begin : g_addr_trunc
      assign w_imm_addr = immM_i[ADDR_WIDTH-1:0];
    end else begin : g_addr_zext
      assign w_imm_addr = {{(ADDR_WIDTH-IMM_WIDTH){1'b0}}, immM_i};
    end
  endgenerate

  // Immediate as a MOV value: sign-extend to DATA_WIDTH.
  generate
    if (IMM_WIDTH == DATA_WIDTH) begin : g_sext_full
      assign w_imm_sext = immM_i;
    end else begin : g_sext_ext
      assign w_imm_sext = {{(DATA_WIDTH-IMM_WIDTH){immM_i[IMM_WIDTH-1]}}, immM_i};
    end
  endgenerate

  assign w_memop    = MemReadM_i | MemWriteM_i;
  assign w_idle_req = w_memop & ~stall_MEM_WB_i;

  // Memory-side address/data; upstream is frozen while BUSY so these stay stable.
  assign dm_we_o    = MemWriteM_i;
  assign dm_addr_o  = w_imm_addr;
  assign dm_wdata_o = MemSrc_i ? ResultW_i : WriteDataM_i;

  // Branch/jump resolution is purely combinational and never gated by stalls.
  assign PC_src_o     = BranchM_i & (dm_wdata_o == '0);
  assign branchAddr_o = w_imm_addr;
  assign jumpAddr_o   = w_imm_addr;
  assign jumpM_o      = jumpM_i;

  assign WBResultM_w  = MovM_i ? w_imm_sext : alu_outM_i;

  // Load data comes from the hold register once WB has released a HELD access.
  assign w_commit_data = !MemReadM_i        ? WBResultM_w :
                         (state_q == S_HELD) ? hold_q      : dm_rdata_i;

  assign WBResultM_o = wbres_q;
  assign WriteRegM_o = wreg_q;
  assign RegWriteM_o = rw_q;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc  = cnt_q + CNT_W'(1);
  assign err_o      = (state_q == S_ERR);
  assign unused_dbg = ^PCM_i;

  // Watchdog: zero outside BUSY, counts BUSY cycles that see no ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != S_BUSY) begin
      cnt_q <= '0;
    end else if (!dm_ack_i) begin
      cnt_q <= w_cnt_inc;
    end
  end
`else
  assign err_o      = 1'b0;
  assign unused_dbg = ^{PCM_i, 32'(TIMEOUT_CYCLES)};
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_idle_req && !dm_ack_i) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dm_ack_i) begin
          state_d = stall_MEM_WB_i ? S_HELD : S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = S_ERR;
        end
`endif
      end
      S_HELD: begin
        if (!stall_MEM_WB_i) begin
          state_d = S_IDLE;
        end
      end
`ifdef MEM_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: memory request and pipeline stall.
  always_comb begin
    dm_req_o = 1'b0;
    stall_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_req_o = w_idle_req;
        stall_o  = w_memop & ~(w_idle_req & dm_ack_i);
      end
      S_BUSY: begin
        dm_req_o = 1'b1;
        stall_o  = ~dm_ack_i | stall_MEM_WB_i;
      end
      S_HELD: begin
        stall_o  = stall_MEM_WB_i;
      end
`ifdef MEM_TIMEOUT_EN
      S_ERR: begin
        stall_o  = 1'b1;
      end
`endif
      default: begin
        dm_req_o = 1'b0;
        stall_o  = 1'b0;
      end
    endcase
  end

  // Park read data that arrives while WB is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if ((state_q == S_BUSY) && dm_ack_i && stall_MEM_WB_i) begin
      hold_q <= dm_rdata_i;
    end
  end

  // MEM/WB register: WB hold wins, then stall bubble, then commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbres_q <= '0;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
    end else if (!stall_MEM_WB_i) begin
      if (stall_o) begin
        rw_q    <= 1'b0;
      end else begin
        wbres_q <= w_commit_data;
        wreg_q  <= WriteRegM_i;
        rw_q    <= RegWriteM_i & ~MemWriteM_i;
      end
    end
  end

endmodule
`default_nettype wire
